// File: rtl/dmem_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_host_ctrl
//  Purpose  : Data-memory subsystem sitting behind the matrix core's DM port.
//             Owns the byte-wide DM array, serves core reads and writes, and
//             gives the host a byte-stream path to LOAD matrices before a run,
//             RUN the core, and DUMP results afterwards. A mode FSM makes sure
//             the host and the core never touch the array in the same cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W  address width, core and host
//    DATA_W  memory word width
//    DEPTH   implemented words; addresses >= DEPTH are out of range
//  Ports
//    clk, rst_n                     clock / asynchronous active-low reset
//    core_addr, core_wr, core_wdata core DM address, write strobe, write data
//                                   (only bits [DATA_W-1:0] are stored)
//    core_rdata                     combinational read data to the core
//    core_run / core_done           core enable / core finished (level)
//    cmd_valid/ready/op/base/len    host command channel
//                                   (op 00 LOAD, 01 DUMP, 10 RUN, 11 CLR_ERR)
//    wr_valid/ready/data            host LOAD byte stream
//    rd_valid/ready/data            host DUMP byte stream (rd_data registered)
//    busy                           registered "not idle"
//    err                            sticky out-of-range access flag
//  Configuration
//    DMEM_PERF_CNT_EN : when defined, adds output run_cycles[31:0], the
//                       number of cycles core_run was high in the last RUN
//                       (cleared on RUN acceptance, saturating).
// ============================================================================
module dmem_host_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_wr,
  input  logic [15:0]       core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_run,
  input  logic              core_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]       run_cycles
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int              c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than an address so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      c_OP_LOAD  = 2'b00;
  localparam logic [1:0]      c_OP_DUMP  = 2'b01;
  localparam logic [1:0]      c_OP_RUN   = 2'b10;
  localparam logic [1:0]      c_OP_CLR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_core_run;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_err;

  // --------------------------------------------------------------------------
  // Command decode and handshakes
  // --------------------------------------------------------------------------
  logic w_cmd_acc;
  logic w_len_zero;
  logic w_start_load;
  logic w_start_dump;
  logic w_start_run;
  logic w_clr_err;
  logic w_load_beat;
  logic w_dump_beat;
  logic w_last;
  logic w_run_end;

  assign w_cmd_acc    = cmd_valid && (r_state == ST_IDLE);
  assign w_len_zero   = (cmd_len == '0);
  // Zero-length LOAD/DUMP is accepted but has no effect at all.
  assign w_start_load = w_cmd_acc && (cmd_op == c_OP_LOAD) && !w_len_zero;
  assign w_start_dump = w_cmd_acc && (cmd_op == c_OP_DUMP) && !w_len_zero;
  assign w_start_run  = w_cmd_acc && (cmd_op == c_OP_RUN);
  assign w_clr_err    = w_cmd_acc && (cmd_op == c_OP_CLR);

  assign w_load_beat  = (r_state == ST_LOAD) && wr_valid;
  assign w_dump_beat  = (r_state == ST_DUMP) && r_rd_valid && rd_ready;
  assign w_last       = (r_cnt == ADDR_W'(1));
  // core_done is only meaningful once the core has actually been enabled.
  assign w_run_end    = r_core_run && core_done;

  // --------------------------------------------------------------------------
  // Address range checks and array read ports
  // --------------------------------------------------------------------------
  logic              w_ptr_inr;
  logic              w_core_inr;
  logic              w_dump_rd;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [ADDR_W-1:0] w_dump_raddr;
  logic              w_dump_inr;
  logic [DATA_W-1:0] w_dump_rdata;

  assign w_ptr_inc  = r_ptr + ADDR_W'(1);
  assign w_ptr_inr  = ({1'b0, r_ptr} < c_DEPTH);
  assign w_core_inr = ({1'b0, core_addr} < c_DEPTH);

  // rd_data always holds mem[ptr]: the first byte is fetched on acceptance,
  // every accepted beat except the last prefetches mem[ptr+1] so the stream
  // has no bubbles.
  assign w_dump_rd    = w_start_dump || (w_dump_beat && !w_last);
  assign w_dump_raddr = w_start_dump ? cmd_base : w_ptr_inc;
  assign w_dump_inr   = ({1'b0, w_dump_raddr} < c_DEPTH);
  assign w_dump_rdata = w_dump_inr ? r_mem[w_dump_raddr[c_IDX_W-1:0]] : '0;

  assign core_rdata   = w_core_inr ? r_mem[core_addr[c_IDX_W-1:0]] : '0;

  // --------------------------------------------------------------------------
  // Array write port: host in LOAD, core while running; never both.
  // --------------------------------------------------------------------------
  logic              w_host_we;
  logic              w_core_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_host_we   = w_load_beat && w_ptr_inr;
  assign w_core_we   = r_core_run && core_wr && w_core_inr;
  assign w_mem_we    = w_host_we || w_core_we;
  assign w_mem_waddr = w_load_beat ? r_ptr   : core_addr;
  assign w_mem_wdata = w_load_beat ? wr_data : core_wdata[DATA_W-1:0];

  // Only the low DATA_W bits of the core write bus are stored.
  logic w_unused_wdata;
  assign w_unused_wdata = ^core_wdata[15:DATA_W];

  // Array contents are deliberately not reset. During reset the FSM is held
  // in IDLE and core_run low, so no write enable can be raised.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr[c_IDX_W-1:0]] <= w_mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Error detection: any out-of-range host beat, dump fetch, or core address
  // presented while the core is running.
  // --------------------------------------------------------------------------
  logic w_err_set;

  assign w_err_set = (w_load_beat && !w_ptr_inr) ||
                     (w_dump_rd   && !w_dump_inr) ||
                     (r_core_run  && !w_core_inr);

  // --------------------------------------------------------------------------
  // Mode FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_load) begin
          w_state_nxt = ST_LOAD;
        end else if (w_start_dump) begin
          w_state_nxt = ST_DUMP;
        end else if (w_start_run) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_load_beat && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DUMP: begin
        if (w_dump_beat && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_run_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_core_run <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_start_load || w_start_dump) begin
        r_ptr <= cmd_base;
        r_cnt <= cmd_len;
      end else if (w_load_beat || w_dump_beat) begin
        // Pointer wraps modulo 2**ADDR_W; out-of-range beats still count.
        r_ptr <= w_ptr_inc;
        r_cnt <= r_cnt - ADDR_W'(1);
      end

      if (w_start_dump) begin
        r_rd_valid <= 1'b1;
      end else if (w_dump_beat && w_last) begin
        r_rd_valid <= 1'b0;
      end

      if (w_dump_rd) begin
        r_rd_data <= w_dump_rdata;
      end

      if (w_start_run) begin
        r_core_run <= 1'b1;
      end else if (w_run_end) begin
        r_core_run <= 1'b0;
      end

      r_busy <= (w_state_nxt != ST_IDLE);

      // A new error wins over a simultaneous clear.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional run-length counter
  // --------------------------------------------------------------------------
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_run_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cycles <= '0;
    end else if (w_start_run) begin
      r_run_cycles <= '0;
    end else if (r_core_run && (r_run_cycles != '1)) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign run_cycles = r_run_cycles;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_ready = (r_state == ST_IDLE);
  assign wr_ready  = (r_state == ST_LOAD);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign core_run  = r_core_run;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_host_ctrl
//  Purpose  : Self-checking bench for dmem_host_ctrl. A transaction-level
//             model (byte array, sticky error bit, current host mode and the
//             expected DUMP byte list) is updated by the driving tasks; a
//             compare process checks the DUT against it on every falling
//             edge. Directed scenarios pin the model with literal values,
//             followed by a randomized command mix.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_host_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4096;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DUMP = 2;
  localparam int M_RUN  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_wr = 1'b0;
  logic [15:0]       core_wdata = '0;
  logic [DATA_W-1:0] core_rdata;
  logic              core_run;
  logic              core_done = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              err;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0]       run_cycles;
`endif

  always #5 clk = ~clk;

  dmem_host_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_addr  (core_addr),
    .core_wr    (core_wr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_run   (core_run),
    .core_done  (core_done),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err)
`ifdef DMEM_PERF_CNT_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  // --------------------------------------------------------------------------
  // Model state
  // --------------------------------------------------------------------------
  logic [7:0] m_mem [DEPTH];
  bit         m_vld [DEPTH];
  bit         m_err = 1'b0;
  int         mode  = M_IDLE;
  logic [7:0] exp_q [$];
  int         rd_idx = 0;
  logic [7:0] dump_got [$];
  logic [7:0] ld_q [$];
  bit         chk_en = 1'b0;
  int         runhi = 0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inr(input logic [15:0] a);
    return a < 16'(DEPTH);
  endfunction

  // Count cycles with core_run high (used by the directed RUN scenario).
  always @(negedge clk) begin
    if (core_run === 1'b1) runhi++;
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(mode == M_IDLE));
      chk("wr_ready",  32'(wr_ready),  32'(mode == M_LOAD));
      chk("busy",      32'(busy),      32'(mode != M_IDLE));
      chk("core_run",  32'(core_run),  32'(mode == M_RUN));
      chk("rd_valid",  32'(rd_valid),  32'(mode == M_DUMP));
      chk("err",       32'(err),       32'(m_err));
      if (mode == M_DUMP && rd_idx < exp_q.size())
        chk("rd_data", 32'(rd_data), 32'(exp_q[rd_idx]));
      if (!inr(core_addr))
        chk("core_rdata_oor", 32'(core_rdata), 32'd0);
      else if (m_vld[core_addr[11:0]])
        chk("core_rdata", 32'(core_rdata), 32'(m_mem[core_addr[11:0]]));
    end
  end

  // --------------------------------------------------------------------------
  // Driving tasks (inputs change 1 ns after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] base, input logic [15:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_base  = 16'($urandom);
    cmd_len   = 16'($urandom);
  endtask

  // LOAD the bytes currently in ld_q starting at base.
  task automatic do_load(input logic [15:0] base, input bit gaps);
    logic [15:0] a;
    int n;
    n = ld_q.size();
    send_cmd(2'b00, base, 16'(n));
    if (n == 0) return;
    mode = M_LOAD;
    a = base;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = ld_q[i];
      tick();
      if (inr(a)) begin
        m_mem[a[11:0]] = ld_q[i];
        m_vld[a[11:0]] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      a = a + 16'd1;
      if (i == n - 1) mode = M_IDLE;
    end
    wr_valid = 1'b0;
  endtask

  // DUMP len bytes from base; received bytes go to dump_got. With
  // fixed_stall, rd_ready is low for three cycles after the second beat.
  task automatic do_dump(input logic [15:0] base, input logic [15:0] len, input bit fixed_stall);
    logic [15:0] a;
    int cyc;
    dump_got.delete();
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      exp_q.push_back(inr(a) ? m_mem[a[11:0]] : 8'h00);
    end
    rd_idx = 0;
    send_cmd(2'b01, base, len);
    if (len == 16'd0) return;
    mode = M_DUMP;
    if (!inr(base)) m_err = 1'b1;
    cyc = 0;
    while (rd_idx < int'(len)) begin
      if (fixed_stall) rd_ready = !(cyc >= 2 && cyc <= 4);
      else             rd_ready = ($urandom_range(0, 2) != 0);
      if (rd_ready) dump_got.push_back(rd_data);
      tick();
      if (rd_ready) begin
        a = base + 16'(rd_idx + 1);
        if (rd_idx + 1 < int'(len) && !inr(a)) m_err = 1'b1;
        rd_idx++;
        if (rd_idx == int'(len)) mode = M_IDLE;
      end
      cyc++;
      if (cyc > 1000) begin
        chk("dump_bound", 32'(rd_idx), 32'(len));
        mode = M_IDLE;
        break;
      end
    end
    rd_ready = 1'b0;
  endtask

  // RUN for n cycles of core_run; core_done is raised in the n-th cycle.
  task automatic do_run(input int n, input bit rnd_wr, input bit allow_oor,
                        input bit fixed, input logic [15:0] fa, input logic [15:0] fd);
    send_cmd(2'b10, 16'($urandom), 16'($urandom));
    mode = M_RUN;
    for (int c = 1; c <= n; c++) begin
      if (fixed && c == 1) begin
        core_addr  = fa;
        core_wr    = 1'b1;
        core_wdata = fd;
      end else begin
        core_addr  = (allow_oor && $urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                                              : 16'($urandom_range(0, DEPTH - 1));
        core_wr    = rnd_wr ? 1'($urandom) : 1'b0;
        core_wdata = 16'($urandom);
      end
      core_done = (c == n);
      tick();
      if (core_wr && inr(core_addr)) begin
        m_mem[core_addr[11:0]] = core_wdata[7:0];
        m_vld[core_addr[11:0]] = 1'b1;
      end
      if (!inr(core_addr)) m_err = 1'b1;
      if (c == n) mode = M_IDLE;
    end
    core_done = 1'b0;
    core_wr   = 1'b0;
`ifdef DMEM_PERF_CNT_EN
    chk("run_cycles", run_cycles, 32'(n));
`endif
  endtask

  // Idle traffic: core writes, core_done and stray stream strobes must all
  // be ignored while no command is active.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      core_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
      core_wr    = 1'($urandom);
      core_wdata = 16'($urandom);
      core_done  = 1'($urandom);
      wr_valid   = 1'($urandom);
      wr_data    = 8'($urandom);
      rd_ready   = 1'($urandom);
      tick();
    end
    core_wr   = 1'b0;
    core_done = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
  endtask

  function automatic logic [15:0] pick_base();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14)      return 16'($urandom_range(0, DEPTH - 1));
    else if (r < 17) return 16'(DEPTH - 4 + int'($urandom_range(0, 3)));
    else             return 16'(65532 + int'($urandom_range(0, 3)));
  endfunction

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  logic [7:0] t_lit [4];

  initial begin
    t_lit[0] = 8'h11; t_lit[1] = 8'h22; t_lit[2] = 8'h33; t_lit[3] = 8'h44;

    // Reset values
    repeat (3) tick();
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_core_run",  32'(core_run),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // Fill the whole array so every later read has a known value.
    ld_q.delete();
    for (int i = 0; i < DEPTH; i++) ld_q.push_back(8'($urandom));
    do_load(16'h0000, 1'b0);

    // Scenario 1: LOAD 4 bytes at 0x0010
    ld_q.delete();
    for (int i = 0; i < 4; i++) ld_q.push_back(t_lit[i]);
    do_load(16'h0010, 1'b1);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      core_addr = 16'h0010 + 16'(i);
      #1;
      chk("t1_mem", 32'(core_rdata), 32'(t_lit[i]));
      tick();
    end

    // Scenario 2: DUMP with a 3-cycle host stall mid-stream
    do_dump(16'h0010, 16'd4, 1'b1);
    chk("t2_count", 32'(dump_got.size()), 32'd4);
    for (int i = 0; i < 4 && i < dump_got.size(); i++)
      chk("t2_byte", 32'(dump_got[i]), 32'(t_lit[i]));

    // Scenario 3: RUN, core writes 0xAB5C to 0x0020, done after 10 cycles
    runhi = 0;
    do_run(10, 1'b0, 1'b0, 1'b1, 16'h0020, 16'hAB5C);
    tick();
    chk("t3_run_len", 32'(runhi), 32'd10);
    core_addr = 16'h0020;
    #1;
    chk("t3_mem", 32'(core_rdata), 32'h5C);
    tick();

    // Scenario 4: core write while IDLE is ignored
    ld_q.delete();
    ld_q.push_back(8'h5A);
    do_load(16'h0030, 1'b0);
    core_addr  = 16'h0030;
    core_wr    = 1'b1;
    core_wdata = 16'h1234;
    repeat (3) tick();
    core_wr = 1'b0;
    chk("t4_no_write", 32'(core_rdata), 32'h5A);
    core_addr = 16'h0012;
    #1;
    chk("t4_track", 32'(core_rdata), 32'h33);
    tick();

    // Scenario 5: LOAD crossing the top of the array, then CLR_ERR
    ld_q.delete();
    ld_q.push_back(8'h77);
    ld_q.push_back(8'h88);
    do_load(16'h0FFF, 1'b0);
    chk("t5_err_set", 32'(err), 32'd1);
    core_addr = 16'h0FFF;
    #1;
    chk("t5_mem_last", 32'(core_rdata), 32'h77);
    core_addr = 16'h1000;
    #1;
    chk("t5_oor_read", 32'(core_rdata), 32'h00);
    tick();
    send_cmd(2'b11, 16'h0000, 16'h0000);
    m_err = 1'b0;
    chk("t5_err_clr", 32'(err), 32'd0);

    // Scenario 6: reset in the middle of a DUMP
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(t_lit[i]);
    rd_idx = 0;
    send_cmd(2'b01, 16'h0010, 16'd4);
    mode = M_DUMP;
    rd_ready = 1'b1;
    tick();
    rd_idx = 1;
    rd_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    mode  = M_IDLE;
    m_err = 1'b0;
    #1;
    chk("t6_rd_valid",  32'(rd_valid),  32'd0);
    chk("t6_busy",      32'(busy),      32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_rd_data",   32'(rd_data),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_dump(16'h0010, 16'd4, 1'b0);
    for (int i = 0; i < 4 && i < dump_got.size(); i++)
      chk("t6_intact", 32'(dump_got[i]), 32'(t_lit[i]));

    // Randomized command mix
    for (int it = 0; it < 120; it++) begin
      int r;
      int n;
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        ld_q.delete();
        n = int'($urandom_range(0, 6));
        for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
        do_load(pick_base(), 1'b1);
      end else if (r <= 5) begin
        do_dump(pick_base(), 16'($urandom_range(0, 6)), 1'b0);
      end else if (r <= 7) begin
        do_run(int'($urandom_range(1, 6)), 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      end else if (r == 8) begin
        send_cmd(2'b11, 16'($urandom), 16'($urandom));
        m_err = 1'b0;
      end else begin
        idle_cycles(int'($urandom_range(1, 3)));
      end
    end

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
